// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the two-master memory arbiter.
//   arb_state_e       - arbiter ownership state (idle, owned by m0, owned by m1)
//   ARB_M0 / ARB_M1   - master identifiers used for last-served tracking
//   MAX_BURST_DEFAULT - default beat cap per ownership when the other master waits
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    localparam int unsigned MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner selection used when the arbiter is idle.
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   - a tie goes to the master that was not served last
//   undefined - fixed priority, m0 wins every tie
// Ports:
//   req0, req1   in  bus requests of master 0 / master 1
//   last_served  in  id of the master granted most recently
//   pick_valid   out at least one request is pending
//   pick         out id of the winning master (valid only with pick_valid)
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic pick_valid,
    output logic pick
);

`ifndef ARB_ROUND_ROBIN_EN
    // History is irrelevant under fixed priority.
    logic unused_last_served;
    assign unused_last_served = last_served;
`endif

    always_comb begin
        pick_valid = req0 | req1;
        pick       = ARB_M0;
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick = (last_served == ARB_M0) ? ARB_M1 : ARB_M0;
`else
            pick = ARB_M0;
`endif
        end else if (req1) begin
            pick = ARB_M1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory/IO bus between the CPU (m0) and a second master (m1).
// Ownership is granted per burst; a burst is cut after MAX_BURST beats if the other
// master is waiting. Read data from the memory is registered and returned with a
// per-master valid one cycle after the read beat.
// Configuration macro: ARB_ROUND_ROBIN_EN (round-robin tie-break; default fixed m0 priority)
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   m0_*/m1_* req,addr,wdata,we master requests and beat attributes
//   m0_gnt/m1_gnt               registered grants (one-hot or zero)
//   m0_rvalid/m1_rvalid, rdata  registered read return
//   address, to_memory, write   memory port driven by the current owner
//   from_memory                 memory read data, combinational on address
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] to_memory,
    output logic              write,
    input  logic [DATA_W-1:0] from_memory
);

    // Counter saturates at the last beat index, so 8 bits cover MAX_BURST up to 255.
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    arb_state_e        state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic              last_q, last_d;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata_q;

    logic beat0, beat1;
    logic rd0, rd1;
    logic pick_valid, pick;

    assign m0_gnt = (state_q == ARB_OWN0);
    assign m1_gnt = (state_q == ARB_OWN1);
    assign beat0  = m0_gnt & m0_req;
    assign beat1  = m1_gnt & m1_req;
    assign rd0    = beat0 & ~m0_we;
    assign rd1    = beat1 & ~m1_we;

    arb_pick u_arb_pick (
        .req0        (m0_req),
        .req1        (m1_req),
        .last_served (last_q),
        .pick_valid  (pick_valid),
        .pick        (pick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;
        unique case (state_q)
            ARB_IDLE: begin
                count_d = '0;
                if (pick_valid) begin
                    state_d = (pick == ARB_M1) ? ARB_OWN1 : ARB_OWN0;
                    last_d  = pick;
                end
            end
            ARB_OWN0: begin
                if (!m0_req) begin
                    // Release: hand straight over if m1 waits, else go idle.
                    count_d = '0;
                    if (m1_req) begin
                        state_d = ARB_OWN1;
                        last_d  = ARB_M1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (count_q == LAST_BEAT && m1_req) begin
                    state_d = ARB_OWN1;
                    last_d  = ARB_M1;
                    count_d = '0;
                end else if (count_q != LAST_BEAT) begin
                    count_d = count_q + 8'd1;
                end
            end
            ARB_OWN1: begin
                if (!m1_req) begin
                    count_d = '0;
                    if (m0_req) begin
                        state_d = ARB_OWN0;
                        last_d  = ARB_M0;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (count_q == LAST_BEAT && m0_req) begin
                    state_d = ARB_OWN0;
                    last_d  = ARB_M0;
                    count_d = '0;
                end else if (count_q != LAST_BEAT) begin
                    count_d = count_q + 8'd1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Memory port follows the owner; an unowned bus drives zeros.
    always_comb begin
        address   = '0;
        to_memory = '0;
        unique case (state_q)
            ARB_OWN0: begin
                address   = m0_addr;
                to_memory = m0_wdata;
            end
            ARB_OWN1: begin
                address   = m1_addr;
                to_memory = m1_wdata;
            end
            default: begin
                address   = '0;
                to_memory = '0;
            end
        endcase
    end

    assign write = (beat0 & m0_we) | (beat1 & m1_we);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            count_q   <= '0;
            last_q    <= ARB_M1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            last_q    <= last_d;
            rvalid0_q <= rd0;
            rvalid1_q <= rd1;
            if (rd0 || rd1) begin
                rdata_q <= from_memory;
            end
        end
    end

    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int MAXB = 4;

    logic       clk;
    logic       reset;
    logic       req   [2];
    logic [7:0] addr  [2];
    logic [7:0] wdata [2];
    logic       we    [2];

    logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, write;
    logic [7:0] rdata, address, to_memory, from_memory;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    int checks   = 0;
    int failures = 0;

    // Reference model state: owner index (-1 none), beats done in this ownership.
    int         own;
    int         done;
    int         last;
    bit         exp_rv [2];
    logic [7:0] exp_rdata;

    mem_arbiter #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .MAX_BURST (MAXB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_req      (req[0]),
        .m0_addr     (addr[0]),
        .m0_wdata    (wdata[0]),
        .m0_we       (we[0]),
        .m1_req      (req[1]),
        .m1_addr     (addr[1]),
        .m1_wdata    (wdata[1]),
        .m1_we       (we[1]),
        .m0_gnt      (m0_gnt),
        .m1_gnt      (m1_gnt),
        .m0_rvalid   (m0_rvalid),
        .m1_rvalid   (m1_rvalid),
        .rdata       (rdata),
        .address     (address),
        .to_memory   (to_memory),
        .write       (write),
        .from_memory (from_memory)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign from_memory = mem[address];
    always @(posedge clk) if (write) mem[address] <= to_memory;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own       = -1;
        done      = 0;
        last      = 1;
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        exp_rdata = 8'h00;
    endtask

    // One clock edge of the arbitration rules, applied to the current requests.
    task automatic model_step();
        int nxt;
        bit beat;
        beat      = (own >= 0) && req[own];
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        if (beat && !we[own]) begin
            exp_rdata   = ref_mem[addr[own]];
            exp_rv[own] = 1'b1;
        end
        if (beat && we[own]) ref_mem[addr[own]] = wdata[own];
        nxt = own;
        if (own < 0) begin
            done = 0;
            if (req[0] && req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                nxt = 1 - last;
`else
                nxt = 0;
`endif
            end else if (req[0]) nxt = 0;
            else if (req[1]) nxt = 1;
        end else if (!beat) begin
            done = 0;
            nxt  = req[1-own] ? 1 - own : -1;
        end else begin
            done++;
            if (done >= MAXB && req[1-own]) begin
                nxt  = 1 - own;
                done = 0;
            end
        end
        if (nxt >= 0 && nxt != own) last = nxt;
        own = nxt;
    endtask

    // Called with inputs settled while clk is low; checks, clocks, returns at next negedge.
    task automatic tick();
        logic [7:0] ea, ed;
        if (reset) model_reset();
        #1;
        ea = (own >= 0) ? addr[own] : 8'h00;
        ed = (own >= 0) ? wdata[own] : 8'h00;
        check("m0_gnt", m0_gnt, own == 0);
        check("m1_gnt", m1_gnt, own == 1);
        check("m0_rvalid", m0_rvalid, exp_rv[0]);
        check("m1_rvalid", m1_rvalid, exp_rv[1]);
        check("rdata", rdata, exp_rdata);
        check("address", address, ea);
        check("to_memory", to_memory, ed);
        check("write", write, (own >= 0) && req[own] && we[own]);
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic set_m(input int i, input logic r, input logic w, input logic [7:0] a,
                         input logic [7:0] d);
        req[i]   = r;
        we[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        model_reset();
        reset = 1'b1;
        set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_m(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // m0 writes 0xA5 to 0x10 then reads it back.
        set_m(0, 1'b1, 1'b1, 8'h10, 8'hA5);
        tick();
        #1;
        check("wr_strobe", write, 1'b1);
        check("wr_addr", address, 8'h10);
        tick();
        we[0] = 1'b0;
        tick();
        check("rd_valid", m0_rvalid, 1'b1);
        check("rd_data", rdata, 8'hA5);
        req[0] = 1'b0;
        tick();
        tick();

        // Simultaneous requests from idle: first tie goes to m0.
        set_m(0, 1'b1, 1'b0, 8'h20, 8'h00);
        set_m(1, 1'b1, 1'b0, 8'h30, 8'h00);
        tick();
        check("tie1_m0_gnt", m0_gnt, 1'b1);
        req[0] = 1'b0;
        req[1] = 1'b0;
        tick();
        tick();
        req[0] = 1'b1;
        req[1] = 1'b1;
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        check("tie2_m1_gnt", m1_gnt, 1'b1);
`else
        check("tie2_m0_gnt", m0_gnt, 1'b1);
`endif
        req[0] = 1'b0;
        req[1] = 1'b0;
        tick();
        tick();

        // Burst cap: m0 streams, m1 joins at beat 2, handover after m0's 4th beat.
        set_m(0, 1'b1, 1'b0, 8'h40, 8'h00);
        set_m(1, 1'b0, 1'b1, 8'h50, 8'h3C);
        tick();
        for (int b = 1; b <= 4; b++) begin
            if (b == 2) req[1] = 1'b1;
            addr[0] = 8'(8'h40 + b);
            tick();
        end
        check("cap_m0_gnt", m0_gnt, 1'b0);
        check("cap_m1_gnt", m1_gnt, 1'b1);
        for (int b = 0; b < 6; b++) tick();
        req[0] = 1'b0;
        req[1] = 1'b0;
        tick();
        tick();

        // m1 single beat then release: bus idles with zero address.
        set_m(1, 1'b1, 1'b1, 8'h60, 8'h77);
        tick();
        tick();
        req[1] = 1'b0;
        tick();
        #1;
        check("rel_m1_gnt", m1_gnt, 1'b0);
        check("rel_addr", address, 8'h00);
        check("rel_write", write, 1'b0);
        tick();

        // m0 alone for 10 beats: grant never drops.
        set_m(0, 1'b1, 1'b0, 8'h60, 8'h00);
        tick();
        for (int b = 0; b < 10; b++) begin
            check("solo_gnt", m0_gnt, 1'b1);
            tick();
        end
        req[0] = 1'b0;
        tick();
        tick();

        // Reset mid-burst after two m0 beats.
        set_m(0, 1'b1, 1'b1, 8'h70, 8'h11);
        tick();
        tick();
        we[0] = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
        check("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        check("rst_rdata", rdata, 8'h00);
        check("rst_write", write, 1'b0);
        tick();
        reset = 1'b0;
        req[0] = 1'b0;
        tick();

        // Randomized traffic; addr/we/wdata held while waiting for a grant.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (req[i] && own != i) begin
                    // waiting: hold everything
                end else if (req[i]) begin
                    req[i] = ($urandom_range(0, 5) != 0);
                    set_m(i, req[i], 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
                end else begin
                    set_m(i, ($urandom_range(0, 2) == 0), 1'($urandom),
                          8'($urandom_range(0, 15)), 8'($urandom));
                end
            end
            reset = ($urandom_range(0, 79) == 0);
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single memory/IO bus (8-bit address, 8-bit write data, write strobe, 8-bit read data) between the CPU and a second bus master (DMA/loader). It sits between the masters and the memory block, muxing address/data/write onto the memory port and returning registered read data. Ownership is granted per-burst, with a burst cap so neither master starves the other.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data width
- MAX_BURST, 4, max consecutive beats per ownership when the other master requests (1..255)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- m0_req / m1_req  in  1  bus request, held high for the whole burst
- m0_addr / m1_addr  in  ADDR_W  beat address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_we / m1_we  in  1  1 = write beat, 0 = read beat
- m0_gnt / m1_gnt  out  1  registered grant (one-hot or zero)
- m0_rvalid / m1_rvalid  out  1  read data valid, one cycle after a read beat
- rdata  out  DATA_W  registered read data (shared)
- address  out  ADDR_W  to memory
- to_memory  out  DATA_W  to memory write data
- write  out  1  to memory write strobe
- from_memory  in  DATA_W  memory read data (combinational on address)

## Operation
- States: ARB_IDLE, ARB_OWN0, ARB_OWN1; grants decoded from state (m0_gnt = state==ARB_OWN0).
- Beat = cycle with owner's req && gnt both high; burst counter increments per beat.
- IDLE: no req → stay; requests → pick winner (see Configuration), go OWNx.
- OWNx, req_x low → other req high ? OWN(other) : IDLE; counter cleared.
- OWNx, beat with counter == MAX_BURST-1 and other req high → OWN(other), counter cleared; otherwise counter saturates and ownership continues.
- Bus mux: address/to_memory follow the owner; no owner → address=0, to_memory=0. write = gnt_x & req_x & we_x (combinational, never high without a beat).
- Read beat: rdata <= from_memory, rvalid of that master high next cycle only; write beats leave rdata unchanged.
- Reset (any time, incl. mid-burst): state IDLE, both gnt 0, both rvalid 0, rdata 0, counter 0, last-served = m1. In-flight beat is dropped.

## Timing
- Request-to-grant: req sampled high at edge n in IDLE → gnt high after edge n; first beat in cycle n+1.
- Handover: no dead cycle; new owner's gnt rises on the same edge the old gnt falls.
- Release: req dropped in cycle k → gnt low after edge k; beat not counted in cycle k.
- Read latency: rvalid/rdata 1 cycle after the read beat; back-to-back reads give rvalid every cycle.
- Masters must hold addr/we/wdata stable while req high and gnt low.

## Configuration
- ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE go to the master not served last; last-served updated on each grant.
- Undefined: fixed priority, m0 always wins ties in IDLE; MAX_BURST handover still applies (prevents m1 starvation only within bursts).

## Structure
- Package mem_arbiter_pkg: state enum (ARB_IDLE, ARB_OWN0, ARB_OWN1), ARB_M0/ARB_M1 ids, default MAX_BURST constant.
- Sub-module arb_pick: combinational winner selection from (req0, req1, last_served), with round-robin/fixed selection under the macro.

## Test plan
- Reset mid-burst (m0 owns, 2 beats done) → next cycle gnt=00, rvalid=00, rdata=0x00, write=0.
- m0 only: write 0xA5 to 0x10, then read 0x10 → write=1 on beat 1 with address=0x10; m0_rvalid=1, rdata=0xA5 one cycle after read beat.
- Both req same cycle from reset → m0 gets grant first (both modes); with ARB_ROUND_ROBIN_EN, next tie goes to m1.
- m0 holds req for 10 beats, m1 requests at beat 2, MAX_BURST=4 → m0 loses gnt after its 4th beat, m1_gnt rises same edge, no idle cycle.
- m1 drops req after 1 beat, m0 idle → IDLE next cycle, address=0x00, write=0.
- m0 alone holds req for 10 beats, MAX_BURST=4 → gnt never drops, counter saturates, 10 beats complete.
